// File: rtl/multi_channel_dummy_adc.sv
// Behavioural N-channel ADC model: trigger/busy/done handshake with a fixed
// conversion latency, per-channel result bank, sticky status word and
// deterministic sample data from a seeded 16-bit Fibonacci LFSR.
// Optional feature macro: DUMMY_ADC_SCAN_EN (scan-all conversion on SCAN_REQ).
module multi_channel_dummy_adc #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int NUM_CHANNELS = 4,
  parameter  int RESOLUTION   = 12,
  parameter  int CONV_CYCLES  = 8,
  parameter  int RAND_SEED    = 1,
  localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ADC_TRIGGER,
  input  logic [CH_W-1:0]         CHANNEL_SEL,
  input  logic                    SCAN_REQ,
  input  logic                    STATUS_CLR,
  input  logic [NUM_CHANNELS-1:0] ANALOG_IN,
  input  logic [CH_W-1:0]         RD_CHANNEL,
  output logic [DATA_WIDTH-1:0]   MEASUREMENT,
  output logic                    DATA_VALID,
  output logic [DATA_WIDTH-1:0]   RD_DATA,
  output logic [DATA_WIDTH-1:0]   STATUS_REG
);

  localparam int              CNT_W    = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CHANNELS - 1);
  localparam logic [15:0]      SEED_RAW = RAND_SEED[15:0];
  localparam logic [15:0]      SEED     = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;

  typedef enum logic [0:0] {
    S_IDLE,
    S_CONVERT
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [RESOLUTION-1:0]   meas_q, meas_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    ovr_q, ovr_d;
  logic                    cerr_q, cerr_d;
  logic [3:0]              last_q, last_d;
  logic                    scan_q, scan_d;

  logic [RESOLUTION-1:0]   bank_q [NUM_CHANNELS];
  logic                    bank_we;
  logic [15:0]             lfsr_nx;
  logic [RESOLUTION-1:0]   res;
  logic                    sel_ok;
  logic                    scan_go;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

`ifdef DUMMY_ADC_SCAN_EN
  assign scan_go = SCAN_REQ;
`else
  logic unused_scan_req;
  assign scan_go         = 1'b0;
  assign unused_scan_req = SCAN_REQ;
`endif

  assign lfsr_nx = lfsr_step(lfsr_q);
  assign res     = ANALOG_IN[ch_q] ? lfsr_nx[RESOLUTION-1:0] : '0;
  assign sel_ok  = (int'(CHANNEL_SEL) < NUM_CHANNELS);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Conversion datapath and sticky status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      ch_q    <= '0;
      lfsr_q  <= SEED;
      meas_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cerr_q  <= 1'b0;
      last_q  <= '0;
      scan_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      lfsr_q  <= lfsr_d;
      meas_q  <= meas_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      cerr_q  <= cerr_d;
      last_q  <= last_d;
      scan_q  <= scan_d;
    end
  end

  // Next-state logic; flag clears are applied first so a same-edge set wins
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    lfsr_d  = lfsr_q;
    meas_d  = meas_q;
    valid_d = 1'b0;
    done_d  = done_q;
    ovr_d   = ovr_q;
    cerr_d  = cerr_q;
    last_d  = last_q;
    scan_d  = scan_q;
    bank_we = 1'b0;

    if (STATUS_CLR) begin
      ovr_d  = 1'b0;
      cerr_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (ADC_TRIGGER) begin
          if (scan_go || sel_ok) begin
            state_d = S_CONVERT;
            cnt_d   = CNT_INIT;
            ch_d    = scan_go ? '0 : CHANNEL_SEL;
            scan_d  = scan_go;
            done_d  = 1'b0;
          end else begin
            cerr_d = 1'b1;
          end
        end
      end
      S_CONVERT: begin
        if (ADC_TRIGGER) ovr_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          lfsr_d  = lfsr_nx;
          meas_d  = res;
          valid_d = 1'b1;
          bank_we = 1'b1;
          last_d  = 4'(ch_q);
          // scan continues straight into the next channel without passing IDLE
          if (scan_q && (ch_q != LAST_CH)) begin
            cnt_d = CNT_INIT;
            ch_d  = ch_q + 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            scan_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-channel result bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) bank_q[i] <= '0;
    end else if (bank_we) begin
      bank_q[ch_q] <= res;
    end
  end

  // Combinational bank read, zero outside the populated channel range
  always_comb begin
    RD_DATA = '0;
    if (int'(RD_CHANNEL) < NUM_CHANNELS) RD_DATA[RESOLUTION-1:0] = bank_q[RD_CHANNEL];
  end

  // Output assembly
  always_comb begin
    MEASUREMENT                   = '0;
    MEASUREMENT[RESOLUTION-1:0]   = meas_q;
    DATA_VALID                    = valid_q;
    STATUS_REG                    = '0;
    STATUS_REG[0]                 = (state_q == S_CONVERT);
    STATUS_REG[1]                 = done_q;
    STATUS_REG[2]                 = ovr_q;
    STATUS_REG[3]                 = cerr_q;
    STATUS_REG[11:8]              = last_q;
  end

endmodule

// File: tb/tb_multi_channel_dummy_adc.sv
// Directed testbench for multi_channel_dummy_adc with a result scoreboard.
module tb_multi_channel_dummy_adc;

  localparam int DW   = 32;
  localparam int NCH  = 4;
  localparam int RES  = 12;
  localparam int CONV = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          adc_trig, scan_req, status_clr;
  logic [1:0]    ch_sel, rd_ch;
  logic [3:0]    analog;
  logic [DW-1:0] meas, rd_data, status;
  logic          data_valid;

  logic          t5_trig, t5_clr;
  logic [2:0]    t5_sel, t5_rd;
  logic [4:0]    t5_analog;
  logic [DW-1:0] t5_meas, t5_rd_data, t5_status;
  logic          t5_valid;

  int            checks = 0;
  int            errors = 0;

  logic [15:0]   m_lfsr;
  logic          m_done, m_ovr;
  logic [3:0]    m_last;
  logic [31:0]   exp_q[$];

  always #5 clk = ~clk;

  multi_channel_dummy_adc #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .RESOLUTION(RES),
    .CONV_CYCLES(CONV), .RAND_SEED(1)
  ) u_dut (
    .clk(clk), .reset(reset), .ADC_TRIGGER(adc_trig), .CHANNEL_SEL(ch_sel),
    .SCAN_REQ(scan_req), .STATUS_CLR(status_clr), .ANALOG_IN(analog),
    .RD_CHANNEL(rd_ch), .MEASUREMENT(meas), .DATA_VALID(data_valid),
    .RD_DATA(rd_data), .STATUS_REG(status)
  );

  // Five channels so out-of-range selects are representable
  multi_channel_dummy_adc #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(5), .RESOLUTION(RES),
    .CONV_CYCLES(CONV), .RAND_SEED(0)
  ) u_dut5 (
    .clk(clk), .reset(reset), .ADC_TRIGGER(t5_trig), .CHANNEL_SEL(t5_sel),
    .SCAN_REQ(1'b0), .STATUS_CLR(t5_clr), .ANALOG_IN(t5_analog),
    .RD_CHANNEL(t5_rd), .MEASUREMENT(t5_meas), .DATA_VALID(t5_valid),
    .RD_DATA(t5_rd_data), .STATUS_REG(t5_status)
  );

  function automatic logic [15:0] m_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [31:0] m_status();
    return {20'h0, m_last, 5'b0, m_ovr, m_done, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // One single-channel conversion; rt_a/rt_b are edges (relative to acceptance)
  // at which a stray trigger is applied, 0 = none. Returns at the DATA_VALID cycle.
  task automatic convert(input int ch, input logic [3:0] an, input int rt_a, input int rt_b);
    logic [31:0] expv;
    logic [31:0] got;
    int cyc;
    int busy_n;
    analog = an;
    m_lfsr = m_step(m_lfsr);
    expv   = an[ch] ? {20'h0, m_lfsr[11:0]} : 32'h0;
    exp_q.push_back(expv);
    adc_trig = 1'b1;
    ch_sel   = ch[1:0];
    @(negedge clk);
    adc_trig = 1'b0;
    m_done   = 1'b0;
    check("status_after_accept", status, m_status() | 32'h1);
    cyc    = 0;
    busy_n = 0;
    while (!data_valid && cyc < CONV + 4) begin
      busy_n  += int'(status[0]);
      adc_trig = (cyc + 1 == rt_a) || (cyc + 1 == rt_b);
      @(negedge clk);
      cyc++;
    end
    adc_trig = 1'b0;
    if (rt_a > 0 || rt_b > 0) m_ovr = 1'b1;
    check("latency", cyc, CONV);
    check("busy_cycles", busy_n, CONV);
    got = exp_q.pop_front();
    check("measurement", meas, got);
    m_done = 1'b1;
    m_last = ch[3:0];
    check("status_done", status, m_status());
    rd_ch = ch[1:0];
    #1;
    check("bank_read", rd_data, got);
  endtask

  initial begin
    int n_valid;
    int cyc;
    reset = 1'b1; adc_trig = 1'b0; scan_req = 1'b0; status_clr = 1'b0;
    ch_sel = '0; rd_ch = '0; analog = 4'hF;
    t5_trig = 1'b0; t5_clr = 1'b0; t5_sel = '0; t5_rd = '0; t5_analog = 5'h1F;
    m_lfsr = 16'h0001; m_done = 1'b0; m_ovr = 1'b0; m_last = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_measurement", meas, 32'h0);
    check("rst_valid", {31'h0, data_valid}, 32'h0);
    check("rst_status", status, 32'h0);
    for (int i = 0; i < NCH; i++) begin
      rd_ch = i[1:0];
      #1;
      check("rst_bank", rd_data, 32'h0);
    end

    // Back-to-back conversions: ch2 -> 0x002, grounded ch1 -> 0, ch0 -> 0x008
    convert(2, 4'hF, 0, 0);
    check("status_ch2", status, 32'h0000_0202);
    convert(1, 4'b1101, 0, 0);
    convert(0, 4'hF, 0, 0);

    // Re-trigger mid-conversion and on the completion edge: single result, overrun
    convert(3, 4'hF, 3, 8);
    check("status_overrun", status, 32'h0000_0306);
    n_valid = 0;
    repeat (10) begin
      @(negedge clk);
      n_valid += int'(data_valid);
    end
    check("no_extra_valid", n_valid, 0);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    m_ovr = 1'b0;
    check("status_after_clr", status, 32'h0000_0302);

    // Reset four cycles into a conversion aborts it
    analog = 4'hF; ch_sel = 2'd2; adc_trig = 1'b1;
    @(negedge clk);
    adc_trig = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    rd_ch = 2'd2;
    #1;
    check("abort_measurement", meas, 32'h0);
    check("abort_status", status, 32'h0);
    check("abort_valid", {31'h0, data_valid}, 32'h0);
    check("abort_bank", rd_data, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_lfsr = 16'h0001; m_done = 1'b0; m_ovr = 1'b0; m_last = '0;
    exp_q.delete();
    n_valid = 0;
    repeat (CONV + 2) begin
      @(negedge clk);
      n_valid += int'(data_valid);
    end
    check("abort_no_valid", n_valid, 0);
    convert(2, 4'hF, 0, 0);
    check("status_after_abort", status, 32'h0000_0202);

    // Out-of-range channel on the five-channel instance
    t5_sel = 3'd5; t5_trig = 1'b1;
    @(negedge clk);
    t5_trig = 1'b0;
    check("chan_err_set", t5_status, 32'h0000_0008);
    t5_rd = 3'd5;
    #1;
    check("rd_out_of_range5", t5_rd_data, 32'h0);
    t5_rd = 3'd7;
    #1;
    check("rd_out_of_range7", t5_rd_data, 32'h0);
    t5_sel = 3'd6; t5_trig = 1'b1; t5_clr = 1'b1;
    @(negedge clk);
    t5_trig = 1'b0; t5_clr = 1'b0;
    check("set_beats_clear", t5_status, 32'h0000_0008);
    t5_clr = 1'b1;
    @(negedge clk);
    t5_clr = 1'b0;
    check("chan_err_clear", t5_status, 32'h0);
    t5_sel = 3'd7; t5_trig = 1'b1;
    @(negedge clk);
    t5_sel = 3'd4; t5_clr = 1'b1;
    @(negedge clk);
    t5_trig = 1'b0; t5_clr = 1'b0;
    check("trig_with_clear", t5_status, 32'h0000_0001);
    cyc = 0;
    while (!t5_valid && cyc < CONV + 4) begin
      @(negedge clk);
      cyc++;
    end
    check("ch4_latency", cyc, CONV);
    check("ch4_measurement", t5_meas, 32'h0000_0002);
    check("ch4_status", t5_status, 32'h0000_0402);
    t5_rd = 3'd4;
    #1;
    check("ch4_bank", t5_rd_data, 32'h0000_0002);

`ifdef DUMMY_ADC_SCAN_EN
    begin
      int stamps[$];
      int busy_n;
      logic [31:0] expv;
      logic [31:0] bank_exp[NCH];
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_lfsr = 16'h0001;
      exp_q.delete();
      for (int i = 0; i < NCH; i++) begin
        m_lfsr = m_step(m_lfsr);
        expv = {20'h0, m_lfsr[11:0]};
        bank_exp[i] = expv;
        exp_q.push_back(expv);
      end
      analog = 4'hF; ch_sel = 2'd3; scan_req = 1'b1; adc_trig = 1'b1;
      @(negedge clk);
      adc_trig = 1'b0; scan_req = 1'b0;
      cyc = 0;
      busy_n = 0;
      while (stamps.size() < NCH && cyc < NCH * CONV + 8) begin
        busy_n += int'(status[0]);
        @(negedge clk);
        cyc++;
        if (data_valid) begin
          stamps.push_back(cyc);
          if (stamps.size() < NCH) check("scan_done_low", {31'h0, status[1]}, 32'h0);
          if (exp_q.size() != 0) check("scan_measurement", meas, exp_q.pop_front());
        end
      end
      check("scan_pulses", stamps.size(), NCH);
      for (int i = 0; i < stamps.size(); i++) check("scan_stamp", stamps[i], (i + 1) * CONV);
      check("scan_busy", busy_n, NCH * CONV);
      check("scan_status", status, 32'h0000_0302);
      for (int i = 0; i < NCH; i++) begin
        rd_ch = i[1:0];
        #1;
        check("scan_bank", rd_data, bank_exp[i]);
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
